// File: rtl/web_select_sequencer.sv
// web_select_sequencer: registered one-hot web driver with fire window, cooldown, status pulses and shot counter
module web_select_sequencer #(
  parameter int SEL_W    = 3,
  parameter int N_WEBS   = 8,
  parameter int FIRE_LEN = 2,
  parameter int COOLDOWN = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [SEL_W-1:0]  select,
  input  logic              fire_req,
  output logic [N_WEBS-1:0] web_out,
  output logic              fire_ack,
  output logic              invalid,
  output logic              dropped,
  output logic              busy,
  output logic [CNT_W-1:0]  shot_cnt
);
  localparam int MAX_T = FIRE_LEN > COOLDOWN ? FIRE_LEN : COOLDOWN;
  localparam int TW = $clog2(MAX_T + 1);
  localparam logic [TW-1:0] FIRE_LOAD = TW'(FIRE_LEN - 1);
  localparam logic [TW-1:0] COOL_LOAD = TW'(COOLDOWN > 0 ? COOLDOWN - 1 : 0);
  localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_WEBS);
  typedef enum logic [1:0] {IDLE, FIRE, COOL} state_t;
  state_t state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [SEL_W-1:0] idx, idx_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic [N_WEBS-1:0] web_nx;
  logic ack_nx, inv_nx, drop_nx, req, ready, done, stop;
  // state, timer, latched index, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      idx      <= '0;
      shot_cnt <= '0;
      web_out  <= '0;
      fire_ack <= 1'b0;
      invalid  <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      idx      <= idx_nx;
      shot_cnt <= cnt_nx;
      web_out  <= web_nx;
      fire_ack <= ack_nx;
      invalid  <= inv_nx;
      dropped  <= drop_nx;
    end
  end
  // next state: the edge that ends a phase also counts as idle, so requests there are accepted
  always_comb begin
    req      = enable && fire_req;
    done     = timer == '0;
    stop     = done || !enable;
    ready    = state == IDLE || (done && (state == COOL || (state == FIRE && COOLDOWN == 0)));
    state_nx = state;
    timer_nx = timer;
    idx_nx   = idx;
    cnt_nx   = shot_cnt;
    ack_nx   = 1'b0;
    inv_nx   = 1'b0;
    drop_nx  = 1'b0;
    if (state == FIRE) begin
      state_nx = stop ? (COOLDOWN > 0 ? COOL : IDLE) : FIRE;
      timer_nx = stop ? COOL_LOAD : timer - TW'(1);
    end else if (state == COOL) begin
      state_nx = done ? IDLE : COOL;
      timer_nx = done ? timer : timer - TW'(1);
    end
    if (req && ready && ({1'b0, select} < N_LIM)) begin
      state_nx = FIRE;
      timer_nx = FIRE_LOAD;
      idx_nx   = select;
      cnt_nx   = shot_cnt + CNT_W'(1);
      ack_nx   = 1'b1;
    end else if (req) begin
      inv_nx  = ready;
      drop_nx = !ready;
    end
    for (int k = 0; k < N_WEBS; k++) web_nx[k] = state_nx == FIRE && idx_nx == SEL_W'(k);
  end
  // busy covers both the fire window and the cooldown
  always_comb busy = state != IDLE;
endmodule

// File: tb/tb_web_select_sequencer.sv
// tb_web_select_sequencer: randomized scoreboard bench for two configurations of web_select_sequencer
module tb_web_select_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, fire_req = 1'b0;
  logic [2:0] select = '0;
  logic [5:0] web0;
  logic [7:0] web1;
  logic ack0, inv0, drop0, busy0, ack1, inv1, drop1, busy1;
  logic [15:0] cnt0;
  logic [1:0] cnt1;
  int checks = 0, failures = 0;
  typedef struct {logic [7:0] web; logic ack, inv, drop, busy; logic [15:0] cnt;} exp_t;
  exp_t q0[$], q1[$];
  int fl[2] = '{2, 1}, cd[2] = '{4, 0}, nw[2] = '{6, 8}, cmod[2] = '{65536, 4};
  longint e_cyc = 0;
  longint fire_end[2], next_ok[2];
  int idx[2], cnt[2];

  always #5 clk = ~clk;

  web_select_sequencer #(.N_WEBS(6)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .select(select), .fire_req(fire_req),
    .web_out(web0), .fire_ack(ack0), .invalid(inv0), .dropped(drop0), .busy(busy0), .shot_cnt(cnt0));

  web_select_sequencer #(.FIRE_LEN(1), .COOLDOWN(0), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .select(select), .fire_req(fire_req),
    .web_out(web1), .fire_ack(ack1), .invalid(inv1), .dropped(drop1), .busy(busy1), .shot_cnt(cnt1));

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      fire_end[d] = 0;
      next_ok[d]  = 0;
      idx[d]      = 0;
      cnt[d]      = 0;
    end
  endtask

  // behavioural model: windows tracked as absolute edge numbers
  task automatic model(input int d, output exp_t x);
    x = '{default: '0};
    if (!enable && e_cyc < fire_end[d]) begin
      fire_end[d] = e_cyc;
      next_ok[d]  = e_cyc + cd[d];
    end
    if (enable && fire_req) begin
      if (e_cyc < next_ok[d]) x.drop = 1'b1;
      else if (int'(select) >= nw[d]) x.inv = 1'b1;
      else begin
        idx[d]      = int'(select);
        fire_end[d] = e_cyc + fl[d];
        next_ok[d]  = e_cyc + fl[d] + cd[d];
        cnt[d]      = (cnt[d] + 1) % cmod[d];
        x.ack       = 1'b1;
      end
    end
    x.web  = e_cyc < fire_end[d] ? 8'(1 << idx[d]) : 8'h0;
    x.busy = e_cyc < next_ok[d];
    x.cnt  = 16'(cnt[d]);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, e_cyc);
    end
  endtask

  task automatic cyc(input logic en, input logic rq, input logic [2:0] sel);
    exp_t x;
    enable = en;
    fire_req = rq;
    select = sel;
    @(posedge clk);
    e_cyc++;
    model(0, x);
    q0.push_back(x);
    model(1, x);
    q1.push_back(x);
    @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    exp_t x;
    if (q0.size() > 0) begin
      x = q0.pop_front();
      chk("web0", 16'(web0), 16'(x.web));
      chk("ack0", 16'(ack0), 16'(x.ack));
      chk("inv0", 16'(inv0), 16'(x.inv));
      chk("drop0", 16'(drop0), 16'(x.drop));
      chk("busy0", 16'(busy0), 16'(x.busy));
      chk("cnt0", cnt0, x.cnt);
    end
    if (q1.size() > 0) begin
      x = q1.pop_front();
      chk("web1", 16'(web1), 16'(x.web));
      chk("ack1", 16'(ack1), 16'(x.ack));
      chk("inv1", 16'(inv1), 16'(x.inv));
      chk("drop1", 16'(drop1), 16'(x.drop));
      chk("busy1", 16'(busy1), 16'(x.busy));
      chk("cnt1", 16'(cnt1), x.cnt);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_web0", 16'(web0), 16'h0);
    chk("rst_busy0", 16'(busy0), 16'h0);
    chk("rst_cnt0", cnt0, 16'h0);
    chk("rst_pulses0", 16'({ack0, inv0, drop0}), 16'h0);
    chk("rst_web1", 16'(web1), 16'h0);
    // single fire at index 5
    cyc(1, 1, 5);
    repeat (7) cyc(1, 0, 0);
    // out-of-range indices
    cyc(1, 1, 7);
    cyc(1, 1, 6);
    cyc(1, 0, 0);
    // request inside cooldown is dropped, then one at E+6 accepted
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 1);
    repeat (6) cyc(1, 0, 0);
    // enable abort mid-fire
    cyc(1, 1, 2);
    repeat (7) cyc(0, 1, 0);
    // back-to-back with select stepping
    for (int i = 0; i < 5; i++) cyc(1, 1, 3'(i));
    repeat (6) cyc(1, 0, 0);
    // asynchronous reset mid-fire
    cyc(1, 1, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_web0", 16'(web0), 16'h0);
    chk("arst_busy0", 16'(busy0), 16'h0);
    chk("arst_cnt0", cnt0, 16'h0);
    chk("arst_web1", 16'(web1), 16'h0);
    chk("arst_cnt1", 16'(cnt1), 16'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 1, 3);
    repeat (4) cyc(1, 0, 0);
    // randomized traffic
    repeat (800) cyc($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, 3'($urandom));
    @(negedge clk);
    #1;
    chk("queue_drain", 16'(q0.size() + q1.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/web_select_sequencer.md
# web_select_sequencer

Registered, parametrised successor to the combinational web-select decoder. Accepts a binary web index and a fire request, then drives a one-hot web output for a fixed fire window, followed by a cooldown during which new requests are dropped. Sits between the user-choice logic and the web actuator drivers. Also reports a handshake acknowledge, invalid-index and dropped-request pulses, and a running shot count.

## Interface
Parameters:
- SEL_W, 3, width of the web index.
- N_WEBS, 8, number of one-hot outputs; must satisfy 1 ≤ N_WEBS ≤ 2**SEL_W.
- FIRE_LEN, 2, number of cycles the one-hot output is held; must be ≥ 1.
- COOLDOWN, 4, number of dead cycles after each fire window; must be ≥ 0.
- CNT_W, 16, width of the shot counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  global enable; low forces the outputs to zero (see Operation).
- select  in  SEL_W  requested web index; bit 0 is the LSB.
- fire_req  in  1  fire request, sampled only in IDLE.
- web_out  out  N_WEBS  registered one-hot output; web_out[k] is high when the latched index equals k.
- fire_ack  out  1  one-cycle pulse marking an accepted request.
- invalid  out  1  one-cycle pulse on a request with select ≥ N_WEBS.
- dropped  out  1  one-cycle pulse on a request arriving while not IDLE.
- busy  out  1  high in FIRE and COOLDOWN.
- shot_cnt  out  CNT_W  count of accepted requests; wraps modulo 2**CNT_W.

## Operation
- **Reset:** when rst_n is low, immediately:
  - state = IDLE;
  - web_out, fire_ack, invalid, dropped, busy = 0;
  - shot_cnt = 0;
  - latched index = 0; timer = 0.
- **IDLE state:**
  - web_out = 0, busy = 0.
  - On a rising edge with enable=1, fire_req=1 and select < N_WEBS:
    - latch select;
    - load timer with FIRE_LEN-1;
    - go to FIRE;
    - set fire_ack=1 for one cycle;
    - increment shot_cnt.
  - On a rising edge with enable=1, fire_req=1 and select ≥ N_WEBS: set invalid=1 for one cycle and stay in IDLE.
  - With enable=0, fire_req is ignored: no pulse of any kind.
- **FIRE state:**
  - web_out = one-hot of the latched index; busy = 1.
  - Timer decrements each cycle.
  - When the timer reaches 0:
    - if COOLDOWN > 0, go to COOLDOWN and load the timer with COOLDOWN-1;
    - if COOLDOWN = 0, go directly to IDLE.
  - If enable is low at an edge, abort: web_out is 0 from the next cycle, and the block goes to COOLDOWN (or to IDLE if COOLDOWN = 0). Cooldown always runs in full.
- **COOLDOWN state:**
  - web_out = 0, busy = 1.
  - Timer decrements each cycle; at 0, go to IDLE.
- **Dropped requests:** fire_req=1 with enable=1 at any edge where the state is FIRE or COOLDOWN sets dropped=1 for one cycle. The request is not queued, and the shot count does not change.
- **Changing select:** a change on select after acceptance has no effect on web_out until the next accepted request.
- **Output invariant:** web_out is always either all-zero or exactly one-hot; it never has two or more bits set.
- **Timer width:** clog2(max(FIRE_LEN, COOLDOWN) + 1) bits.

## Timing
- **Latency:** request sampled at edge E; web_out, fire_ack, busy and the incremented shot_cnt are all visible after edge E.
- **Fire window:** web_out is held for exactly FIRE_LEN cycles, following edges E through E+FIRE_LEN-1. It is zero after edge E+FIRE_LEN.
- **Busy duration:** busy stays high for FIRE_LEN+COOLDOWN cycles.
- **Next request:** the earliest edge at which another request can be accepted is E+FIRE_LEN+COOLDOWN.
- **Back-to-back firing:** with COOLDOWN = 0 and fire_req held high, a request is accepted every FIRE_LEN cycles. web_out may switch directly from one one-hot value to another in the same cycle that fire_ack pulses again.
- **Pulse outputs:** fire_ack, invalid and dropped are registered single-cycle pulses, mutually exclusive in any cycle.
- **Reset mid-operation:** outputs clear asynchronously, without waiting for a clock. The first acceptance is possible at the first edge after rst_n deasserts.

## Test plan
- **Reset check:** assert rst_n=0 mid-FIRE, between edges. Expect web_out=0, busy=0 and shot_cnt=0 immediately, with no clock edge.
- **Single fire, defaults:** select=3'd5, fire_req=1 for one edge. Expect:
  - web_out=8'b0010_0000 for 2 cycles;
  - busy high for 6 cycles;
  - fire_ack pulses once;
  - shot_cnt=1.
- **Invalid index:** N_WEBS=6, select=3'd7, fire_req=1. Expect invalid=1 for one cycle, state stays IDLE, web_out=0, shot_cnt unchanged.
- **Drop during cooldown:** fire at select=0, then fire_req at edge E+3. Expect dropped=1 for one cycle and web_out never becomes 8'b0000_0010. A request at E+6 is accepted.
- **Enable abort:** fire select=2, drop enable low after edge E. Expect web_out=0 from edge E+1, busy high through E+4 (full 4-cycle cooldown), then IDLE.
- **Back-to-back with wrap:** COOLDOWN=0, FIRE_LEN=1, CNT_W=2, fire_req held high with select stepping 0,1,2,3,4. Expect:
  - web_out steps through one-hot values every cycle;
  - fire_ack high every cycle;
  - shot_cnt reads 1,2,3,0,1.
